// File: rtl/ddr_resp_pkg.sv
// Shared types and widths for the DDR responder: FSM state encoding and line/word geometry.
package ddr_resp_pkg;

  localparam int DDR_BEATS  = 8;
  localparam int DDR_WORD_W = 64;
  localparam int DDR_LINE_W = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_XFER,
    ST_DRAIN,
    ST_DONE
  } ddr_resp_state_t;

endpackage

// File: rtl/ddr_responder_if.sv
// DDR request channel between the arbiter (master) and the memory-side responder (slave).
interface ddr_responder_if;
  import ddr_resp_pkg::*;

  logic                  ddr_chip_enable;
  logic [63:0]           ddr_index;
  logic                  ddr_write_enable;
  logic                  ddr_burst_mode;
  logic [DDR_LINE_W-1:0] ddr_write_data;
  logic [DDR_LINE_W-1:0] ddr_read_data;
  logic                  ddr_operation_done;
  logic                  ddr_ready;
  logic                  ddr_error;

  modport master (
    output ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode, ddr_write_data,
    input  ddr_read_data, ddr_operation_done, ddr_ready, ddr_error
  );

  modport slave (
    input  ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode, ddr_write_data,
    output ddr_read_data, ddr_operation_done, ddr_ready, ddr_error
  );

endinterface

// File: rtl/ddr_resp_mem.sv
// Single-port 64-bit word array with synchronous read; contents are deliberately not reset.
module ddr_resp_mem
  import ddr_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  ce,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DDR_WORD_W-1:0] wdata,
  output logic [DDR_WORD_W-1:0] rdata
);

  logic [DDR_WORD_W-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (ce) begin
      if (we) mem_q[addr] <= wdata;
      else    rdata       <= mem_q[addr];
    end
  end

endmodule

// File: rtl/ddr_responder.sv
// DDR request responder: latency wait, then single or 8-beat burst access to the backing array.
// Optional out-of-range checking on the upper index bits when DDR_RESP_OOR_CHECK_EN is defined.
//
// state    | meaning
// ST_IDLE  | ready, waiting for ddr_chip_enable
// ST_WAIT  | counting down the access latency
// ST_XFER  | one array access per beat
// ST_DRAIN | capture the last read word returned by the array
// ST_DONE  | one-cycle completion pulse
module ddr_responder
  import ddr_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 4
) (
  input logic            clock,
  input logic            reset,
  ddr_responder_if.slave ddr
);

  ddr_resp_state_t       state_q, state_d;
  logic [7:0]            lat_q, lat_d;
  logic [2:0]            beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  we_q, we_d;
  logic                  burst_q, burst_d;
  logic [DDR_LINE_W-1:0] wdata_q, wdata_d;
  logic                  oor_q, oor_d;
  logic                  ready_q, ready_d;
  logic                  pend_q, pend_d;
  logic [2:0]            pend_lane_q, pend_lane_d;
  logic [DDR_LINE_W-1:0] rdata_q, rdata_d;

  logic                  mem_ce, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DDR_WORD_W-1:0] mem_wdata, mem_rdata, cap_word;
  logic                  req_oor;

`ifdef DDR_RESP_OOR_CHECK_EN
  assign req_oor = |ddr.ddr_index[63:ADDR_WIDTH];
`else
  logic unused_idx_hi;
  assign req_oor       = 1'b0;
  assign unused_idx_hi = ^ddr.ddr_index[63:ADDR_WIDTH];
`endif

  assign cap_word = oor_q ? '0 : mem_rdata;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    beat_d      = beat_q;
    idx_d       = idx_q;
    we_d        = we_q;
    burst_d     = burst_q;
    wdata_d     = wdata_q;
    oor_d       = oor_q;
    ready_d     = ready_q;
    pend_d      = 1'b0;
    pend_lane_d = beat_q;
    rdata_d     = rdata_q;
    mem_ce      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = burst_q ? {idx_q[ADDR_WIDTH-1:3], beat_q} : idx_q;
    mem_wdata   = wdata_q[{beat_q, 6'd0} +: DDR_WORD_W];

    // Array read data arrives one cycle after its beat; lane 0 starts a fresh line.
    if (pend_q) begin
      if (pend_lane_q == 3'd0) begin
        rdata_d                 = '0;
        rdata_d[DDR_WORD_W-1:0] = cap_word;
      end else begin
        rdata_d[{pend_lane_q, 6'd0} +: DDR_WORD_W] = cap_word;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (ddr.ddr_chip_enable) begin
          idx_d   = ddr.ddr_index[ADDR_WIDTH-1:0];
          we_d    = ddr.ddr_write_enable;
          burst_d = ddr.ddr_burst_mode;
          wdata_d = ddr.ddr_write_data;
          oor_d   = req_oor;
          beat_d  = 3'd0;
          lat_d   = 8'(LATENCY);
          ready_d = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        lat_d = lat_q - 8'd1;
        if (lat_q == 8'd1) state_d = ST_XFER;
      end
      ST_XFER: begin
        mem_ce = 1'b1;
        mem_we = we_q & ~oor_q;
        pend_d = ~we_q;
        beat_d = beat_q + 3'd1;
        if (!burst_q || beat_q == 3'd7) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lat_q       <= '0;
      beat_q      <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      burst_q     <= 1'b0;
      wdata_q     <= '0;
      oor_q       <= 1'b0;
      ready_q     <= 1'b1;
      pend_q      <= 1'b0;
      pend_lane_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      beat_q      <= beat_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      burst_q     <= burst_d;
      wdata_q     <= wdata_d;
      oor_q       <= oor_d;
      ready_q     <= ready_d;
      pend_q      <= pend_d;
      pend_lane_q <= pend_lane_d;
      rdata_q     <= rdata_d;
    end
  end

  ddr_resp_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clock (clock),
    .ce    (mem_ce),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign ddr.ddr_ready          = ready_q;
  assign ddr.ddr_operation_done = (state_q == ST_DONE);
  assign ddr.ddr_read_data      = rdata_q;
`ifdef DDR_RESP_OOR_CHECK_EN
  assign ddr.ddr_error          = (state_q == ST_DONE) & oor_q;
`else
  assign ddr.ddr_error          = 1'b0;
`endif

endmodule

// File: doc/ddr_responder.md
# ddr_responder

Memory-side responder for the core's DDR request channel: it accepts a single-cycle `ddr_chip_enable` request, waits a programmable access latency, then performs a single 64-bit or burst 512-bit read or write against an internal word array. It completes each request with a one-cycle `ddr_operation_done` pulse. It sits outside `core_top`, facing the channel arbiter's DDR port, and serves as the simulation and FPGA backing store for icache and dcache refills and writebacks.

## Interface

Parameters:
- `ADDR_WIDTH`, default 16 — word-index bits; array depth is 2^ADDR_WIDTH 64-bit words.
- `LATENCY`, default 4 — WAIT cycles before the data transfer starts; legal range 1..255.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high. The clock port is named `clock` and the reset port `reset`.
- `clock` input 1 — sole clock; all logic is on the rising edge.
- `reset` input 1 — synchronous, active-high.
- `ddr_chip_enable` input 1 — request strobe, sampled only while `ddr_ready`=1.
- `ddr_index` input 64 — 64-bit word index; bits [ADDR_WIDTH-1:0] address the array.
- `ddr_write_enable` input 1 — 1 = write, 0 = read.
- `ddr_burst_mode` input 1 — 1 = 8-word (512-bit) burst, 0 = single word.
- `ddr_write_data` input 512 — write payload; lane k is bits [64k+63:64k].
- `ddr_read_data` output 512 — read result, registered.
- `ddr_operation_done` output 1 — one-cycle completion pulse.
- `ddr_ready` output 1 — idle and able to accept a request.
- `ddr_error` output 1 — out-of-range pulse, coincident with done; see Configuration.

## Operation

- **FSM states:** IDLE, WAIT, XFER, DRAIN, DONE.
- **IDLE:** `ddr_ready`=1. If `ddr_chip_enable`=1, capture index, write enable, burst mode and write data, clear the beat counter, load the latency counter with LATENCY, and go to WAIT. If `ddr_chip_enable`=0, stay in IDLE.
- **WAIT:** decrement the latency counter; when it reaches 1, go to XFER.
- **XFER:** one array access per cycle at beat k.
  - Burst address = {idx[ADDR_WIDTH-1:3], k[2:0]}; the low 3 index bits are ignored, so bursts are 8-word aligned and never cross an aligned block.
  - Single address = idx[ADDR_WIDTH-1:0] with k=0 only.
  - Writes store lane k. Reads issue the address for beat k; the returned data lands in lane k one cycle later.
  - After the last beat (k=7 for a burst, k=0 for a single access), go to DRAIN.
- **DRAIN:** capture the final read word and go to DONE. For writes, no capture occurs.
- **DONE:** `ddr_operation_done`=1 for exactly this cycle, then return to IDLE.
- **Single read:** lane 0 holds the word; lanes 1..7 are zero.
- **Write results:** a write leaves `ddr_read_data` unchanged.
- **Read data hold:** `ddr_read_data` is stable from DONE until the next read's first capture.
- **Requests while busy:** `ddr_chip_enable` while `ddr_ready`=0 is ignored; no queuing.
- **Reset mid-operation:** the FSM returns to IDLE, no done pulse is produced, and an in-flight burst write may be partially committed. The array contents are not reset.

## Timing

- Reset values: `ddr_ready`=1, `ddr_operation_done`=0, `ddr_error`=0, `ddr_read_data`=0, FSM=IDLE.
- For a request accepted at cycle T with B beats (B=1 or 8):
  - WAIT occupies T+1..T+LATENCY.
  - XFER occupies T+LATENCY+1..T+LATENCY+B.
  - DRAIN is at T+LATENCY+B+1.
  - Done is at T+LATENCY+B+2.
  - `ddr_ready` returns to 1 at T+LATENCY+B+3.
- `ddr_ready` drops at T+1, driven by a register updated on accept.
- Back-to-back throughput is one request per LATENCY+B+3 cycles.
- The array has a synchronous read with 1-cycle latency and a write taking effect at the end of the access cycle.

## Configuration

- Macro: `DDR_RESP_OOR_CHECK_EN`.
- Defined: a request whose `ddr_index`[63:ADDR_WIDTH] is nonzero is out of range.
  - Writes are suppressed.
  - Reads return all zeros.
  - `ddr_error` pulses in the DONE cycle.
  - Timing is unchanged.
- Undefined: upper index bits are silently truncated (aliasing), and `ddr_error` is tied to 0.

## Structure

- Shared package `ddr_resp_pkg` holds:
  - the state enum `ddr_resp_state_t`;
  - `DDR_BEATS`=8, `DDR_WORD_W`=64, `DDR_LINE_W`=512.
- Sub-module `ddr_resp_mem`: a single-port 2^ADDR_WIDTH × 64 array with ports `clock`, `ce`, `we`, `addr`, `wdata`, `rdata`. It has a synchronous read and no reset.

## Test plan

- **Reset value check:** hold `reset` for 3 cycles with `ddr_chip_enable`=1 → no accept; after release `ddr_ready`=1, done=0, `ddr_read_data`=0.
- **Single write/read, LATENCY=4:**
  - Write index 0x10, data[63:0]=0xDEADBEEF_CAFEF00D; done at T+7.
  - Then read 0x10 → done at T+7, lane0=0xDEADBEEF_CAFEF00D, lanes1..7=0.
- **Burst write/read:**
  - Burst write index 0x43 with lane k = 0x1111_1111_1111_1111·(k+1); done at T+14.
  - Burst read index 0x40 → identical 512-bit line.
  - Single read index 0x45 → 0x6666_6666_6666_6666.
- **Busy strobe ignored:** pulse `ddr_chip_enable` (write, index 0x20) in every WAIT and XFER cycle of a burst read → exactly one done; word 0x20 unchanged.
- **Reset mid-burst:** assert `reset` at the 3rd XFER beat of a burst read → no done pulse; `ddr_ready`=1 the cycle after release; the next single read completes normally.
- **Out-of-range index, `DDR_RESP_OOR_CHECK_EN` defined, ADDR_WIDTH=16:**
  - Write index 0x1_0005 → `ddr_error`=1 with done; word 0x0005 unchanged.
  - Without the macro, the same write lands at 0x0005 and `ddr_error`=0.
